mdu_seq: RTL and testbench

- Iterative multiply/divide sequencer for the MIPS32 core's MULT, MULTU, DIV and DIVU instructions.
- Owns the architectural HI/LO registers.
- Uses one WIDTH-bit add/subtract step per cycle: shift-add for multiply, restoring division for divide.
- Sits beside the single-cycle ALU in EX; the hazard unit stalls on busy.

---
 rtl/mdu_seq.sv | 161 ++++++++++++++++
 tb/tb_mdu_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional early multiply termination: `define MDU_EARLY_OUT_EN
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZDIV} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;

    logic             sgn;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign sgn   = ~op[0];
    assign sa    = sgn & srcA[WIDTH-1];
    assign sb    = sgn & srcB[WIDTH-1];
    assign mag_a = sa ? -srcA : srcA;
    assign mag_b = sb ? -srcB : srcB;

    // acc:mq is the shared double-width working register
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] dsub;
    logic             ge;

    assign msum = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign shl  = {acc, mq[WIDTH-1]};
    assign ge   = shl >= {1'b0, opnd};
    assign dsub = shl[WIDTH-1:0] - opnd;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               early;

`ifdef MDU_EARLY_OUT_EN
    // multiplier bits not yet consumed sit in mq[WIDTH-1-cnt:0]
    assign early = ~is_div & ((mq & ({WIDTH{1'b1}} >> cnt)) == '0);
    assign prod  = {acc, mq} >> (CW'(WIDTH) - cnt);
`else
    assign early = 1'b0;
    assign prod  = {acc, mq};
`endif

    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = neg_q ? -mq : mq;
    assign r_fix    = neg_r ? -acc : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            mq       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !abort) begin
                        is_div   <= op[1];
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
                        opnd     <= op[1] ? mag_b : mag_a;
                        mq       <= op[1] ? mag_a : mag_b;
                        acc      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        state    <= (op[1] && srcB == '0) ? ZDIV : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (early) begin
                        state <= FIX;
                    end else begin
                        if (is_div) begin
                            acc <= ge ? dsub : shl[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], ge};
                        end else begin
                            acc <= msum[WIDTH:1];
                            mq  <= {msum[0], mq[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    if (!abort) begin
                        if (is_div) begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ZDIV: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        cnt <= CW'(1);
                    end else begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and random checks of mdu_seq against an
// arithmetic reference model of HI/LO, busy, done and div_zero.
module tb_mdu_seq;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         abort;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .abort(abort),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    // reference: result and completion offset (edges after acceptance)
    function automatic void model_op(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] h,
                                     output logic [31:0] l, output bit z, output int lat);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        logic [31:0] bm;
        int          k;
        z = 0; lat = W + 1; h = '0; l = '0; bm = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = sa * sb;
                {h, l} = p;
                bm = b[31] ? -b : b;
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                {h, l} = up;
            end
            2'b10: begin
                if (b == 0) begin z = 1; lat = 2; end
                else begin
                    q = sa / sb; r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin z = 1; lat = 2; end
                else begin l = a / b; h = a % b; end
            end
        endcase
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            k = 0;
            while (k < W && (bm >> k) != 0) k++;
            lat = (k == W) ? W + 1 : k + 2;
        end
`endif
    endfunction

    bit          m_busy, m_done, m_dz, r_z;
    logic [31:0] m_hi, m_lo, r_hi, r_lo;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_dz = 0;
            m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (abort) m_busy = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_done = 1;
                        if (r_z) m_dz = 1;
                        else begin m_hi = r_hi; m_lo = r_lo; end
                    end
                end
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start && !abort) begin
                    model_op(op, srcA, srcB, r_hi, r_lo, r_z, m_left);
                    m_busy = 1;
                    m_dz = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("div_zero", 32'(div_zero), 32'(m_dz));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1; op = o; srcA = a; srcB = b;
        tick();
        start = 0;
        op = 2'($urandom);
        srcA = $urandom;
        srcB = $urandom;
    endtask

    // returns in the done cycle; at = edges after acceptance, -1 on timeout
    task automatic wait_done(output int at, output int nbusy);
        at = -1; nbusy = 0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin at = i; break; end
            if (busy) nbusy++;
            tick();
        end
        if (at < 0) chk("done_timeout", 32'(at), 32'd0);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_busy"}, 32'(busy), 32'd0);
        chk({n, "_done"}, 32'(done), 32'd0);
        chk({n, "_dz"}, 32'(div_zero), 32'd0);
        chk({n, "_hi"}, hi, 32'd0);
        chk({n, "_lo"}, lo, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            4: return -32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    int at, nb, nd;

    initial begin
        rst_n = 0; start = 0; op = 0; srcA = 0; srcB = 0;
        abort = 0; hi_we = 0; lo_we = 0; wdata = 0;
        repeat (2) tick();
        chk_zero("reset");
        rst_n = 1;
        chk_en = 1;
        tick();

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(at, nb);
        chk("multu_lat", 32'(at), 32'd33);
        chk("multu_busy", 32'(nb), 32'd33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        tick();
        chk("multu_done_once", 32'(done), 32'd0);

        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(at, nb);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(at, nb);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        hi_we = 1; wdata = 32'h1234;
        tick();
        hi_we = 0; lo_we = 1; wdata = 32'h5678;
        tick();
        lo_we = 0;
        launch(2'b11, 32'd5, 32'd0);
        wait_done(at, nb);
        chk("dz_lat", 32'(at), 32'd2);
        chk("dz_flag", 32'(div_zero), 32'd1);
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'h5678);

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(at, nb);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_dz", 32'(div_zero), 32'd0);
        launch(2'b11, 32'd100, 32'd7);
        wait_done(at, nb);
        chk("b2b_lat", 32'(at), 32'd33);
        chk("b2b_lo", lo, 32'd14);
        chk("b2b_hi", hi, 32'd2);

        launch(2'b01, 32'h00AB_CDEF, 32'h0001_2345);
        repeat (10) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", 32'(busy), 32'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            tick();
        end
        chk("abort_nodone", 32'(nd), 32'd0);
        chk("abort_hi", hi, 32'd2);
        chk("abort_lo", lo, 32'd14);

        launch(2'b01, 32'd2, 32'd3);
        start = 1; op = 2'b00; srcA = 32'd99; srcB = 32'd99;
        hi_we = 1; wdata = 32'hDEAD;
        tick();
        start = 0; hi_we = 0;
        wait_done(at, nb);
        chk("busy_ign_hi", hi, 32'd0);
        chk("busy_ign_lo", lo, 32'd6);

        launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) tick();
        #1;
        rst_n = 0;
        #1;
        chk_zero("async_rst");
        rst_n = 1;
        tick();

        launch(2'b01, 32'h1234, 32'd3);
        wait_done(at, nb);
`ifdef MDU_EARLY_OUT_EN
        chk("early_lat", 32'(at <= 4), 32'd1);
`else
        chk("fixed_lat", 32'(at), 32'd33);
`endif
        chk("early_hi", hi, 32'd0);
        chk("early_lo", lo, 32'h369C);

        for (int c = 0; c < 4000; c++) begin
            start = ($urandom % 3) == 0;
            op    = 2'($urandom);
            srcA  = pick();
            srcB  = pick();
            abort = ($urandom % 40) == 0;
            hi_we = ($urandom % 12) == 0;
            lo_we = ($urandom % 12) == 0;
            wdata = $urandom;
            tick();
        end
        start = 0; abort = 0; hi_we = 0; lo_we = 0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
